// File: rtl/ducq_nco_if.sv
// NCO sequencer bus: rate strobe, FCW handshake, ROM address/data and carrier outputs.
interface ducq_nco_if #(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned MAG_W   = 8
) ();
  logic               sample_en;
  logic               phase_clr;
  logic [PHASE_W-1:0] fcw_in;
  logic               fcw_valid;
  logic               fcw_ready;
  logic [ADDR_W-1:0]  cos_addr;
  logic [MAG_W-1:0]   cos_q;
  logic [ADDR_W-1:0]  sin_addr;
  logic [MAG_W-1:0]   sin_q;
  logic [MAG_W:0]     cos_out;
  logic [MAG_W:0]     sin_out;
  logic               out_valid;

  modport master (
    output sample_en, phase_clr, fcw_in, fcw_valid, cos_q, sin_q,
    input  fcw_ready, cos_addr, sin_addr, cos_out, sin_out, out_valid
  );

  modport slave (
    input  sample_en, phase_clr, fcw_in, fcw_valid, cos_q, sin_q,
    output fcw_ready, cos_addr, sin_addr, cos_out, sin_out, out_valid
  );
endinterface

// File: rtl/ducq_nco_ctrl.sv
// Quadrature carrier NCO sequencer: phase accumulator, eighth-wave ROM folding and sign/swap rebuild.
// Optional phase dither on the folding path is enabled by defining DUCQ_NCO_DITHER_EN.
module ducq_nco_ctrl #(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned MAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  ducq_nco_if.slave   bus
);

  localparam int unsigned FOLD_W = ADDR_W + 3;
  localparam int unsigned OUT_W  = MAG_W + 1;

  typedef enum logic {S_IDLE, S_PEND} fcw_state_e;

  fcw_state_e          state;
  fcw_state_e          state_nxt;
  logic                fcw_take;
  logic                fcw_xfer;

  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W-1:0]  fcw;
  logic [PHASE_W-1:0]  fcw_pend;
  logic                sample_go;

  logic [FOLD_W-1:0]   fold;
  logic [2:0]          oct;
  logic [ADDR_W-1:0]   addr_a;
  logic [ADDR_W-1:0]   addr_fold;

  logic                v1;
  logic                swap1;
  logic                cneg1;
  logic                sneg1;
  logic [MAG_W-1:0]    cmag;
  logic [MAG_W-1:0]    smag;
  logic [OUT_W-1:0]    cos_c;
  logic [OUT_W-1:0]    sin_c;

  // A clear on the same cycle drops the sample.
  assign sample_go = bus.sample_en && !bus.phase_clr;

  // FCW handshake state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture an offered word while idle; hand it to the accumulator on the next live sample.
  always_comb begin
    state_nxt = state;
    fcw_take  = 1'b0;
    fcw_xfer  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.fcw_valid) begin
          fcw_take  = 1'b1;
          state_nxt = S_PEND;
        end
      end
      S_PEND: begin
        if (sample_go) begin
          fcw_xfer  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef DUCQ_NCO_DITHER_EN
  localparam int unsigned        DITH_W    = PHASE_W - 12;
  localparam logic [PHASE_W-1:0] DITH_MASK = PHASE_W'((64'd1 << DITH_W) - 64'd1);

  logic [15:0]        lfsr;
  logic [PHASE_W-1:0] dither;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
    end else if (sample_go) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Dither touches only the folding copy; the accumulator stays clean.
  always_comb begin
    dither = PHASE_W'(lfsr) & DITH_MASK;
    fold   = FOLD_W'((phase + dither) >> (PHASE_W - FOLD_W));
  end
`else
  assign fold = phase[PHASE_W-1 -: FOLD_W];
`endif

  // Odd octants walk the eighth-wave backwards.
  always_comb begin
    oct       = fold[FOLD_W-1 -: 3];
    addr_a    = fold[ADDR_W-1:0];
    addr_fold = oct[0] ? ~addr_a : addr_a;
  end

  // Octant reconstruction from the two eighth-wave magnitudes.
  always_comb begin
    cmag  = swap1 ? bus.sin_q : bus.cos_q;
    smag  = swap1 ? bus.cos_q : bus.sin_q;
    cos_c = cneg1 ? -{1'b0, cmag} : {1'b0, cmag};
    sin_c = sneg1 ? -{1'b0, smag} : {1'b0, smag};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase         <= '0;
      fcw           <= '0;
      fcw_pend      <= '0;
      bus.fcw_ready <= 1'b1;
      bus.cos_addr  <= '0;
      bus.sin_addr  <= '0;
      v1            <= 1'b0;
      swap1         <= 1'b0;
      cneg1         <= 1'b0;
      sneg1         <= 1'b0;
      bus.cos_out   <= '0;
      bus.sin_out   <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.fcw_ready <= (state_nxt == S_IDLE);
      if (fcw_take) begin
        fcw_pend <= bus.fcw_in;
      end
      if (fcw_xfer) begin
        fcw <= fcw_pend;
      end

      if (bus.phase_clr) begin
        phase <= '0;
      end else if (sample_go) begin
        phase <= phase + fcw;
      end

      // Stage 0: ROM address and octant controls.
      if (sample_go) begin
        bus.cos_addr <= addr_fold;
        bus.sin_addr <= addr_fold;
        swap1        <= oct[0] ^ oct[1];
        cneg1        <= oct[2] ^ oct[1];
        sneg1        <= oct[2];
      end
      v1 <= sample_go;

      // Stage 1 -> 2: register the signed carrier; a clear kills the in-flight sample.
      bus.out_valid <= v1 && !bus.phase_clr;
      if (v1 && !bus.phase_clr) begin
        bus.cos_out <= cos_c;
        bus.sin_out <= sin_c;
      end
    end
  end

endmodule

// File: tb/tb_ducq_nco_ctrl.sv
// Self-checking bench for ducq_nco_ctrl: directed octant/mirror/handshake/clear scenarios plus random traffic.
module tb_ducq_nco_ctrl;

  localparam int unsigned PHASE_W = 24;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned MAG_W   = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  ducq_nco_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .MAG_W(MAG_W)) bus ();

  ducq_nco_ctrl #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .MAG_W(MAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stub ROMs: C(x) = floor(255 - x/4), S(x) = floor(x/2).
  always_comb begin
    bus.cos_q = 8'((10'd1020 - 10'(bus.cos_addr)) >> 2);
    bus.sin_q = 8'(bus.sin_addr >> 1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference model state.
  typedef struct {
    int due;
    int c;
    int s;
  } res_t;

  int          cyc = 0;
  bit          m_known = 1'b0;
  logic [23:0] m_phase;
  logic [23:0] m_fcw;
  logic [23:0] m_pend_w;
  bit          m_pend;
  int          m_addr;
  int          exp_c;
  int          exp_s;
  res_t        q[$];
  bit          rec = 1'b0;
  int          obs_c[$];
  int          obs_s[$];

  // Full-circle sample from a phase, straight from the octant table.
  function automatic void ref_sample(input logic [23:0] p, output int addr, output int c, output int s);
    int oct;
    int a;
    int cm;
    int sm;
    oct  = int'(p[23:21]);
    a    = int'(p[20:12]);
    addr = (oct % 2 == 1) ? 511 - a : a;
    cm   = (1020 - addr) / 4;
    sm   = addr / 2;
    case (oct)
      0: begin c =  cm; s =  sm; end
      1: begin c =  sm; s =  cm; end
      2: begin c = -sm; s =  cm; end
      3: begin c = -cm; s =  sm; end
      4: begin c = -cm; s = -sm; end
      5: begin c = -sm; s = -cm; end
      6: begin c =  sm; s = -cm; end
      default: begin c = cm; s = -sm; end
    endcase
  endfunction

  // One clock: check outputs of the previous edge, drive inputs, advance the model.
  task automatic cycle(input bit r, input bit se, input bit clr, input bit fv, input logic [23:0] fw);
    bit   ev;
    bit   acc;
    res_t h;
    int   a;
    int   c;
    int   s;
    @(negedge clk);
    if (m_known) begin
      ev = (q.size() > 0) && (q[0].due == cyc);
      if (ev) begin
        h     = q.pop_front();
        exp_c = h.c;
        exp_s = h.s;
      end
      chk("out_valid", int'(bus.out_valid), int'(ev));
      chk("fcw_ready", int'(bus.fcw_ready), int'(!m_pend));
      chk("cos_addr", int'(bus.cos_addr), m_addr);
      chk("sin_addr", int'(bus.sin_addr), m_addr);
      chk("cos_out", int'($signed(bus.cos_out)), exp_c);
      chk("sin_out", int'($signed(bus.sin_out)), exp_s);
      if (ev && rec) begin
        obs_c.push_back(int'($signed(bus.cos_out)));
        obs_s.push_back(int'($signed(bus.sin_out)));
      end
    end
    rst           = r;
    bus.sample_en = se;
    bus.phase_clr = clr;
    bus.fcw_valid = fv;
    bus.fcw_in    = fw;
    if (r) begin
      m_phase  = '0;
      m_fcw    = '0;
      m_pend_w = '0;
      m_pend   = 1'b0;
      m_addr   = 0;
      exp_c    = 0;
      exp_s    = 0;
      q.delete();
      m_known  = 1'b1;
    end else begin
      acc = fv && !m_pend;
      if (clr) begin
        m_phase = '0;
        q.delete();
      end else if (se) begin
        ref_sample(m_phase, a, c, s);
        m_addr = a;
        q.push_back('{due: cyc + 2, c: c, s: s});
        m_phase = m_phase + m_fcw;
        if (m_pend) begin
          m_fcw  = m_pend_w;
          m_pend = 1'b0;
        end
      end
      if (acc) begin
        m_pend   = 1'b1;
        m_pend_w = fw;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  int walk_c[8] = '{255, 255, 0, -127, -255, -255, 0, 127};
  int walk_s[8] = '{0, 127, 255, 255, 0, -127, -255, -255};

  initial begin
    int v;
    rst           = 1'b1;
    bus.sample_en = 1'b0;
    bus.phase_clr = 1'b0;
    bus.fcw_valid = 1'b0;
    bus.fcw_in    = '0;

    // Reset, then idle.
    cycle(1, 0, 0, 0, 24'h0);
    cycle(1, 0, 0, 0, 24'h0);
    repeat (5) cycle(0, 0, 0, 0, 24'h0);

    // Octant walk at an eighth-turn per sample.
    cycle(0, 0, 0, 1, 24'h200000);
    cycle(0, 0, 0, 0, 24'h0);
    rec = 1'b1;
    repeat (18) cycle(0, 1, 0, 0, 24'h0);
    repeat (3) cycle(0, 0, 0, 0, 24'h0);
    rec = 1'b0;
    chk("walk_count", obs_c.size(), 18);
    for (int i = 0; i < 16; i++) begin
      v = (i + 1 < obs_c.size()) ? obs_c[i + 1] : 9999;
      chk("walk_cos", v, walk_c[i % 8]);
      v = (i + 1 < obs_s.size()) ? obs_s[i + 1] : 9999;
      chk("walk_sin", v, walk_s[i % 8]);
    end

    // Mirroring in octant 1: address counts down.
    cycle(0, 0, 1, 0, 24'h0);
    cycle(0, 0, 0, 1, 24'h001000);
    cycle(0, 1, 0, 0, 24'h0);
    for (int k = 0; k < 8; k++) begin
      cycle(0, 1, 0, 0, 24'h0);
      #1;
      chk("mirror_addr", int'(bus.cos_addr), 511 - k);
    end

    // Wrap through 24'hFFF000 + 24'h1000.
    cycle(0, 0, 1, 1, 24'hFFF000);
    cycle(0, 1, 0, 0, 24'h0);
    cycle(0, 0, 1, 1, 24'h001000);
    repeat (4) cycle(0, 1, 0, 0, 24'h0);
    repeat (3) cycle(0, 0, 0, 0, 24'h0);

    // Handshake: offer, second offer ignored while pending, transfer on sample.
    cycle(0, 0, 0, 1, 24'h400000);
    #1;
    chk("hs_ready_low", int'(bus.fcw_ready), 0);
    cycle(0, 0, 0, 1, 24'h123456);
    cycle(0, 0, 0, 0, 24'h0);
    cycle(0, 1, 0, 0, 24'h0);
    repeat (4) cycle(0, 1, 0, 0, 24'h0);
    repeat (3) cycle(0, 0, 0, 0, 24'h0);

    // Clear colliding with a sample mid-stream.
    repeat (4) cycle(0, 1, 0, 0, 24'h0);
    cycle(0, 1, 1, 0, 24'h0);
    cycle(0, 1, 0, 0, 24'h0);
    repeat (3) cycle(0, 0, 0, 0, 24'h0);
    #1;
    chk("clr_cos", int'($signed(bus.cos_out)), 255);
    chk("clr_sin", int'($signed(bus.sin_out)), 0);

    // Zero FCW: every sample lands on address 0.
    cycle(0, 0, 1, 1, 24'h0);
    cycle(0, 1, 0, 0, 24'h0);
    repeat (64) cycle(0, 1, 0, 0, 24'h0);
    repeat (3) cycle(0, 0, 0, 0, 24'h0);

    // Random traffic including occasional mid-stream reset.
    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 49) == 0,
            $urandom_range(0, 4) == 0,
            24'($urandom));
    end
    repeat (3) cycle(0, 0, 0, 0, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
